// File: rtl/motor_driver.sv
`default_nettype none
// ============================================================================
// Module      : motor_driver
// Description : Dual H-bridge driver with soft duty ramping and dead-time.
//               Decodes a one-hot motion command into per-motor polarity and
//               drives the polarity pins and a shared PWM duty. Any polarity
//               change or stop ramps the duty down to zero and then holds
//               every bridge input low for a dead-time, so the bridge never
//               shoots through or reverses abruptly.
//
// Ports       : clkin      - system clock
//               reset      - synchronous, active-high reset
//               direction  - one-hot command (FWD/IDLE/BWD/LEFT/RIGHT)
//               enable     - drive enable; low forces an immediate stop
//               in1..in4   - left fwd, left rev, right fwd, right rev pins
//               ena, enb   - left / right motor PWM enables
//               busy       - high while ramping or in dead-time
//               fault      - high while the command is not a legal code
//               duty       - current duty value (telemetry)
//
// Revision    : 1.0 - initial release
// ============================================================================
module motor_driver #(
    parameter int PWM_BITS  = 8,
    parameter int DUTY_MAX  = 200,
    parameter int RAMP_STEP = 8,
    parameter int RAMP_DIV  = 1000,
    parameter int DEADTIME  = 5000
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic [4:0]          direction,
    input  logic                enable,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    output logic                in4,
    output logic                ena,
    output logic                enb,
    output logic                busy,
    output logic                fault,
    output logic [PWM_BITS-1:0] duty
);

    localparam int c_PRE_W  = $clog2(RAMP_DIV);
    localparam int c_DEAD_W = $clog2(DEADTIME + 1);

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(RAMP_DIV - 1);
    localparam logic [c_DEAD_W-1:0] c_DEAD_LOAD = c_DEAD_W'(DEADTIME);
    localparam logic [c_DEAD_W-1:0] c_DEAD_ONE  = c_DEAD_W'(1);
    localparam logic [PWM_BITS:0]   c_STEP_WIDE = (PWM_BITS + 1)'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   c_MAX_WIDE  = (PWM_BITS + 1)'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] c_DUTY_MAX  = PWM_BITS'(DUTY_MAX);

    // Polarity is kept directly in pin order {in1,in2,in3,in4}:
    // per motor 2'b10 = forward, 2'b01 = reverse, 2'b00 = stop.
    localparam logic [3:0] c_POL_STOP = 4'b0000;
    localparam logic [3:0] c_POL_FWD  = 4'b1010;
    localparam logic [3:0] c_POL_BWD  = 4'b0101;
    localparam logic [3:0] c_POL_LEFT = 4'b0110;
    localparam logic [3:0] c_POL_RGHT = 4'b1001;

    typedef enum logic [2:0] {
        ST_STOPPED   = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DEAD      = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_pol;
    logic [3:0]            w_pol_nxt;
    logic [3:0]            r_tgt;
    logic                  r_fault;
    logic [PWM_BITS-1:0]   r_duty;
    logic [PWM_BITS-1:0]   w_duty_nxt;
    logic [c_PRE_W-1:0]    r_pre;
    logic [c_PRE_W-1:0]    w_pre_nxt;
    logic [c_DEAD_W-1:0]   r_dead;
    logic [c_DEAD_W-1:0]   w_dead_nxt;
    logic [PWM_BITS-1:0]   r_cnt;
    logic                  r_pwm;

    logic [3:0]            w_tgt;
    logic                  w_legal;
    logic                  w_tick;
    logic                  w_drive;
    logic                  w_ramping;
    logic [PWM_BITS:0]     w_up_sum;
    logic [PWM_BITS:0]     w_dn_diff;
    logic [PWM_BITS-1:0]   w_up_clamp;
    logic [PWM_BITS-1:0]   w_dn_clamp;

    // ------------------------------------------------------------------
    // Command decode (registered into r_tgt / r_fault)
    // ------------------------------------------------------------------
    always_comb begin
        w_tgt   = c_POL_STOP;
        w_legal = 1'b1;
        case (direction)
            5'b00001: w_tgt = c_POL_FWD;
            5'b00010: w_tgt = c_POL_STOP;
            5'b00100: w_tgt = c_POL_BWD;
            5'b01000: w_tgt = c_POL_LEFT;
            5'b10000: w_tgt = c_POL_RGHT;
            default:  w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Duty arithmetic: one bit wider than the duty, then clamped so the
    // ramp can never wrap past zero or overshoot full speed.
    // ------------------------------------------------------------------
    always_comb begin
        w_up_sum   = {1'b0, r_duty} + c_STEP_WIDE;
        w_dn_diff  = {1'b0, r_duty} - c_STEP_WIDE;
        w_up_clamp = (w_up_sum > c_MAX_WIDE) ? c_DUTY_MAX : w_up_sum[PWM_BITS-1:0];
        w_dn_clamp = w_dn_diff[PWM_BITS] ? '0 : w_dn_diff[PWM_BITS-1:0];
    end

    assign w_tick    = (r_pre == c_PRE_LAST);
    assign w_drive   = (r_state == ST_RAMP_UP) || (r_state == ST_RUN) ||
                       (r_state == ST_RAMP_DOWN);
    assign w_ramping = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_pol_nxt   = r_pol;
        w_dead_nxt  = r_dead;

        if (!enable) begin
            // Immediate stop, no dead-time: every bridge input goes low now.
            w_state_nxt = ST_STOPPED;
            w_duty_nxt  = '0;
            w_pol_nxt   = c_POL_STOP;
            w_dead_nxt  = '0;
        end else begin
            case (r_state)
                ST_STOPPED: begin
                    w_duty_nxt = '0;
                    w_dead_nxt = '0;
                    if (r_tgt != c_POL_STOP) begin
                        w_pol_nxt   = r_tgt;
                        w_state_nxt = ST_RAMP_UP;
                    end
                end

                ST_RAMP_UP: begin
                    // A target change beats a coincident tick: no step applied.
                    if (r_tgt != r_pol) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end else if (r_duty >= c_DUTY_MAX) begin
                        w_duty_nxt  = c_DUTY_MAX;
                        w_state_nxt = ST_RUN;
                    end else if (w_tick) begin
                        w_duty_nxt = w_up_clamp;
                        if (w_up_clamp == c_DUTY_MAX) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    w_duty_nxt = c_DUTY_MAX;
                    if (r_tgt != r_pol) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end
                end

                ST_RAMP_DOWN: begin
                    // Command reverted before reaching zero: climb back from
                    // wherever the duty currently is, skipping the dead-time.
                    if ((r_tgt == r_pol) && (r_tgt != c_POL_STOP)) begin
                        w_state_nxt = ST_RAMP_UP;
                    end else if (r_duty == '0) begin
                        w_state_nxt = ST_DEAD;
                        w_dead_nxt  = c_DEAD_LOAD;
                    end else if (w_tick) begin
                        w_duty_nxt = w_dn_clamp;
                        if (w_dn_clamp == '0) begin
                            w_state_nxt = ST_DEAD;
                            w_dead_nxt  = c_DEAD_LOAD;
                        end
                    end
                end

                ST_DEAD: begin
                    // Loaded with DEADTIME on entry; the edge that takes it
                    // from 1 to 0 is the expiry, giving DEADTIME dead cycles.
                    if (r_dead <= c_DEAD_ONE) begin
                        w_dead_nxt = '0;
                        if (r_tgt == c_POL_STOP) begin
                            w_state_nxt = ST_STOPPED;
                        end else begin
                            w_pol_nxt   = r_tgt;
                            w_state_nxt = ST_RAMP_UP;
                        end
                    end else begin
                        w_dead_nxt = r_dead - c_DEAD_ONE;
                    end
                end

                default: begin
                    w_state_nxt = ST_STOPPED;
                    w_duty_nxt  = '0;
                    w_pol_nxt   = c_POL_STOP;
                    w_dead_nxt  = '0;
                end
            endcase
        end
    end

    // Prescaler restarts on every state change so each ramp state sees its
    // first step a full RAMP_DIV cycles after entry.
    always_comb begin
        w_pre_nxt = '0;
        if ((w_state_nxt == r_state) && w_ramping && !w_tick) begin
            w_pre_nxt = r_pre + c_PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state <= ST_STOPPED;
            r_pol   <= c_POL_STOP;
            r_tgt   <= c_POL_STOP;
            r_fault <= 1'b0;
            r_duty  <= '0;
            r_pre   <= '0;
            r_dead  <= '0;
            r_cnt   <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pol   <= w_pol_nxt;
            r_tgt   <= w_tgt;
            r_fault <= ~w_legal;
            r_duty  <= w_duty_nxt;
            r_pre   <= w_pre_nxt;
            r_dead  <= w_dead_nxt;
            r_cnt   <= r_cnt + PWM_BITS'(1);
            r_pwm   <= enable && w_drive && (r_cnt < r_duty);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign {in1, in2, in3, in4} = w_drive ? r_pol : c_POL_STOP;
    assign ena   = r_pwm;
    assign enb   = r_pwm;
    assign busy  = w_ramping || (r_state == ST_DEAD);
    assign fault = r_fault;
    assign duty  = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_motor_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_driver
// Description : Self-checking bench for motor_driver. Directed scenarios
//               (ramp-up, reversal, aborted reversal, stop/illegal code,
//               enable drop, reset in dead-time) followed by randomized
//               command sequences checked against rule-level expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_driver;

    localparam int PWM_BITS  = 8;
    localparam int DUTY_MAX  = 200;
    localparam int RAMP_STEP = 50;
    localparam int RAMP_DIV  = 4;
    localparam int DEADTIME  = 8;

    localparam logic [4:0] c_FWD   = 5'b00001;
    localparam logic [4:0] c_IDLE  = 5'b00010;
    localparam logic [4:0] c_BWD   = 5'b00100;
    localparam logic [4:0] c_LEFT  = 5'b01000;
    localparam logic [4:0] c_RIGHT = 5'b10000;

    logic                clkin = 1'b0;
    logic                reset;
    logic                enable;
    logic [4:0]          direction;
    logic                in1, in2, in3, in4, ena, enb, busy, fault;
    logic [PWM_BITS-1:0] duty;
    logic [3:0]          w_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    assign w_in = {in1, in2, in3, in4};

    always #5 clkin = ~clkin;

    motor_driver #(
        .PWM_BITS  (PWM_BITS),
        .DUTY_MAX  (DUTY_MAX),
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV),
        .DEADTIME  (DEADTIME)
    ) u_dut (
        .clkin     (clkin),
        .reset     (reset),
        .direction (direction),
        .enable    (enable),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .ena       (ena),
        .enb       (enb),
        .busy      (busy),
        .fault     (fault),
        .duty      (duty)
    );

    // ---------------- reference model (rule level) ----------------
    function automatic logic [3:0] exp_pol(input logic [4:0] d);
        case (d)
            c_FWD:   return 4'b1010;
            c_BWD:   return 4'b0101;
            c_LEFT:  return 4'b0110;
            c_RIGHT: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] d);
        return $countones(d) == 1;
    endfunction

    // Duty k cycles after entering a ramp state from d0.
    function automatic int ramp_up_at(input int d0, input int k);
        int v;
        v = d0 + (k / RAMP_DIV) * RAMP_STEP;
        return (v > DUTY_MAX) ? DUTY_MAX : v;
    endfunction

    function automatic int ramp_down_at(input int d0, input int k);
        int v;
        v = d0 - (k / RAMP_DIV) * RAMP_STEP;
        return (v < 0) ? 0 : v;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in"},   w_in, 0);
        check({tag, "_ena"},  ena,  0);
        check({tag, "_enb"},  enb,  0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_duty"}, duty, 0);
    endtask

    task automatic settle(input logic [4:0] d, input string tag);
        bit moving;
        enable    = 1'b1;
        direction = d;
        steps(120);
        moving = (exp_pol(d) != 4'b0000);
        check({tag, "_in"},    w_in, exp_pol(d));
        check({tag, "_duty"},  duty, moving ? DUTY_MAX : 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_fault"}, fault, !is_legal(d));
    endtask

    // From FORWARD RUN, command a stop-type code and follow it to STOPPED.
    task automatic stop_seq(input logic [4:0] d, input bit exp_fault, input string tag);
        direction = d;
        for (int k = 1; k <= 26; k++) begin
            step();
            check({tag, "_fault"}, fault, exp_fault);
            check({tag, "_in"},    w_in, (k <= 17) ? 4'b1010 : 4'b0000);
            check({tag, "_duty"},  duty, (k < 2) ? DUTY_MAX : ramp_down_at(DUTY_MAX, k - 2));
            check({tag, "_busy"},  busy, (k >= 2) && (k <= 25));
            if (k >= 19) begin
                check({tag, "_ena"}, ena, 0);
                check({tag, "_enb"}, enb, 0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         cnt_a;
        int         cnt_b;
        int         diff;
        logic [3:0] prev_in;
        int         prev_duty;
        logic [4:0] d;
        bit         en;
        int         hold;
        int         pick;

        reset     = 1'b1;
        enable    = 1'b0;
        direction = c_IDLE;
        steps(3);
        check("rst_in",    w_in,  0);
        check("rst_ena",   ena,   0);
        check("rst_enb",   enb,   0);
        check("rst_busy",  busy,  0);
        check("rst_fault", fault, 0);
        check("rst_duty",  duty,  0);
        reset = 1'b0;
        step();

        // Ramp-up to FORWARD
        enable    = 1'b1;
        direction = c_FWD;
        for (int k = 1; k <= 18; k++) begin
            step();
            check("up_in",   w_in, (k >= 2) ? 4'b1010 : 4'b0000);
            check("up_duty", duty, (k >= 2) ? ramp_up_at(0, k - 2) : 0);
            check("up_busy", busy, (k >= 2) && (k < 18));
        end

        // PWM high-time over one full counter period
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            cnt_a += int'(ena);
            cnt_b += int'(enb);
        end
        check("pwm_ena_count", cnt_a, DUTY_MAX);
        check("pwm_enb_count", cnt_b, DUTY_MAX);

        // Reversal FORWARD -> BACKWARD
        direction = c_BWD;
        for (int k = 1; k <= 42; k++) begin
            step();
            if (k <= 17) begin
                check("rev_in",   w_in, 4'b1010);
                check("rev_duty", duty, (k < 2) ? DUTY_MAX : ramp_down_at(DUTY_MAX, k - 2));
                check("rev_busy", busy, k >= 2);
            end else if (k <= 25) begin
                check("rev_dead_in",   w_in, 4'b0000);
                check("rev_dead_duty", duty, 0);
                check("rev_dead_busy", busy, 1);
                if (k >= 19) begin
                    check("rev_dead_ena", ena, 0);
                    check("rev_dead_enb", enb, 0);
                end
            end else begin
                check("rev_up_in",   w_in, 4'b0101);
                check("rev_up_duty", duty, ramp_up_at(0, k - 26));
                check("rev_up_busy", busy, k < 42);
            end
        end

        // Aborted reversal: FORWARD -> LEFT -> FORWARD at duty 100
        settle(c_FWD, "settle_fwd1");
        direction = c_LEFT;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("abort_dn_in",   w_in, 4'b1010);
            check("abort_dn_duty", duty, (k < 2) ? DUTY_MAX : ramp_down_at(DUTY_MAX, k - 2));
            check("abort_dn_busy", busy, k >= 2);
        end
        direction = c_FWD;
        for (int j = 1; j <= 10; j++) begin
            step();
            check("abort_up_in",   w_in, 4'b1010);
            check("abort_up_duty", duty, (j < 2) ? 100 : ramp_up_at(100, j - 2));
            check("abort_up_busy", busy, j < 10);
        end

        // Stop through an illegal code, then through IDLE
        stop_seq(5'b00011, 1'b1, "illegal");
        settle(c_FWD, "settle_fwd2");
        stop_seq(c_IDLE, 1'b0, "idle");

        // Enable drop mid ramp-up
        direction = c_FWD;
        steps(10);
        check("drop_pre_duty", duty, 100);
        check("drop_pre_in",   w_in, 4'b1010);
        enable = 1'b0;
        step();
        check_quiet("drop");
        direction = c_RIGHT;
        step();
        check_quiet("drop_hold1");
        step();
        check_quiet("drop_hold2");
        enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("restart_in",   w_in, 4'b1001);
            check("restart_duty", duty, ramp_up_at(0, k - 1));
            check("restart_busy", busy, k < 17);
        end

        // Synchronous reset during dead-time
        direction = c_IDLE;
        steps(20);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_in",   w_in, 0);
        reset = 1'b1;
        step();
        check_quiet("rst_dead");
        check("rst_dead_fault", fault, 0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("post_rst_quiet", {w_in, ena, enb, busy, fault, duty}, 0);
        end

        // Randomized command sequences
        prev_in   = w_in;
        prev_duty = int'(duty);
        for (int it = 0; it < 20; it++) begin
            pick = $urandom_range(0, 6);
            if (pick <= 4)      d = 5'(1 << pick);
            else if (pick == 5) d = 5'b00000;
            else                d = 5'b00011 | (5'($urandom) & 5'b11100);
            en   = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 30);
            direction = d;
            enable    = en;
            for (int h = 0; h < hold; h++) begin
                step();
                check("rnd_fault", fault, !is_legal(d));
                check("rnd_duty_range", (int'(duty) <= DUTY_MAX) && (int'(duty) % RAMP_STEP == 0), 1);
                check("rnd_no_direct_reverse",
                      (prev_in != 4'b0) && (w_in != 4'b0) && (w_in != prev_in), 0);
                if (!en) begin
                    check_quiet("rnd_disabled");
                end else begin
                    diff = int'(duty) - prev_duty;
                    if (diff < 0) diff = -diff;
                    check("rnd_slope", diff <= RAMP_STEP, 1);
                end
                prev_in   = w_in;
                prev_duty = int'(duty);
            end
            settle(d, "rnd_settle");
            prev_in   = w_in;
            prev_duty = int'(duty);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_driver.md
Name: motor_driver

Overview:
Consumes the one-hot 5-bit `direction` command from the motion FSM and drives a dual H-bridge: one left motor, one right motor. Each motor gets two polarity pins and one PWM enable. The block ramps the duty cycle up and down with a soft slope. Any change of motor polarity, and any stop, goes through ramp-down to zero and then a dead-time with all bridge inputs low, so the bridge never shoots through or reverses abruptly.

Parameters:
PWM_BITS, 8, width of the PWM counter and duty register
DUTY_MAX, 200, full-speed duty (must be < 2^PWM_BITS)
RAMP_STEP, 8, duty increment/decrement per ramp tick
RAMP_DIV, 1000, clkin cycles per ramp tick (>=2)
DEADTIME, 5000, clkin cycles with all bridge inputs low after ramp-down (>=1)

Ports:
clkin  in  1  system clock
reset  in  1  synchronous, active-high reset
direction  in  5  one-hot command: 00001 FORWARD, 00010 IDLE, 00100 BACKWARD, 01000 LEFT, 10000 RIGHT
enable  in  1  drive enable; low forces immediate stop
in1  out  1  left motor forward pin
in2  out  1  left motor reverse pin
in3  out  1  right motor forward pin
in4  out  1  right motor reverse pin
ena  out  1  left motor PWM
enb  out  1  right motor PWM
busy  out  1  high in RAMP_UP, RAMP_DOWN, DEAD
fault  out  1  high while `direction` is not one of the five legal codes
duty  out  PWM_BITS  current duty value (debug/telemetry)

Behaviour:
- Decoded target polarity {L,R}, each motor one of F/R/S:
  - FORWARD = {F,F}
  - BACKWARD = {R,R}
  - LEFT = {R,F}
  - RIGHT = {F,R}
  - IDLE = {S,S}
  - Any illegal code (zero, multi-hot) = {S,S` and `fault`=1, registered, 1-cycle latency.
- Latched polarity `pol` is applied to `in1..in4` only in RAMP_UP, RUN and RAMP_DOWN. In STOPPED and DEAD, `in1..in4` = 0.
- Ramp prescaler:
  - Clears to 0 on every state change.
  - Tick when the count reaches RAMP_DIV-1; the count then wraps to 0.
  - The first duty step therefore occurs RAMP_DIV cycles after entering a ramp state.
- States:
  - STOPPED: duty=0. If enable=1 and target != {S,S}: latch pol=target, go to RAMP_UP.
  - RAMP_UP: on tick, duty = min(duty+RAMP_STEP, DUTY_MAX). At duty==DUTY_MAX go to RUN. If target != pol, go to RAMP_DOWN; duty is kept, not reset.
  - RUN: duty=DUTY_MAX. If target != pol, go to RAMP_DOWN.
  - RAMP_DOWN: on tick, duty = duty-RAMP_STEP, saturating at 0. If target == pol and target != {S,S} before duty hits 0, go back to RAMP_UP from the current duty. At duty==0, go to DEAD and load the dead counter with DEADTIME.
  - DEAD: count down. At 0: if target=={S,S}, go to STOPPED; else latch pol=target and go to RAMP_UP. Target changes during DEAD are only sampled at expiry.
- Arithmetic: compute the add/subtract one bit wider than PWM_BITS, then clamp to [0, DUTY_MAX]. No wrap-around.
- PWM:
  - Free-running PWM_BITS counter, wraps at 2^PWM_BITS-1.
  - ena = enb = (cnt < duty) && state in {RAMP_UP, RUN, RAMP_DOWN}; registered, 1-cycle latency.
  - duty=0 gives constant 0. Duty is never 100%: DUTY_MAX < 2^PWM_BITS.
- enable low (any state, any cycle): next cycle duty=0, `in1..in4`=0, ena=enb=0, state=STOPPED, no dead-time. Restart requires enable=1 plus a non-stop target.
- Reset: all outputs 0, state STOPPED, pol={S,S}, all counters 0. Reset mid-ramp aborts immediately, same as enable low.
- Simultaneous events:
  - A tick in the same cycle as a target change in RAMP_UP: the state transition wins and the duty step is not applied.
  - enable low overrides all other conditions.

Test Plan:
Sim parameters for all scenarios: RAMP_DIV=4, RAMP_STEP=50, DUTY_MAX=200, DEADTIME=8, PWM_BITS=8.
- Ramp-up: reset, enable=1, direction=00001 -> in1..in4=1010; duty steps 50/100/150/200 every 4 cycles; RUN after 16 cycles; ena high exactly 200 of each 256 cycles.
- Reversal: in RUN, direction=00100 -> duty 150/100/50/0 every 4 cycles with in=1010; then 8 cycles with in=0000 and ena=enb=0; then in=0101 and ramp-up; busy high throughout.
- Abort reversal: FORWARD RUN, switch to LEFT, return to FORWARD when duty=100 -> RAMP_UP resumes from 100, no DEAD entered, in stays 1010.
- Stop and illegal code: direction=00011 in RUN -> fault=1 one cycle later; ramp to 0, DEAD 8 cycles, STOPPED with in=0000. direction=00010 behaves the same but with fault=0.
- Enable drop: enable=0 mid RAMP_UP (duty=100) -> next cycle duty=0, in=0000, ena=enb=0, busy=0; enable=1 with RIGHT -> in=1001 and ramp from 0.
- Sync reset during DEAD -> all outputs 0 on the next edge; without enable/direction activity, no output toggles afterwards.
